// File: rtl/rc4_pkg.sv
// rc4_pkg: shared FSM state type and RC4 constants
package rc4_pkg;
  localparam int RC4_SBOX_DEPTH = 256;
  localparam int RC4_DROP_COUNT = 768;
  typedef enum logic [1:0] {ST_IDLE, ST_INIT, ST_KSA, ST_PRGA} rc4_state_e;
endpackage

// File: rtl/rc4_sbox_ram.sv
// rc4_sbox_ram: 256x8 S-box, one read and one write port, registered read, write-first on collision
module rc4_sbox_ram
  import rc4_pkg::*;
(
  input  logic       clk,
  input  logic       we,
  input  logic [7:0] waddr,
  input  logic [7:0] wdata,
  input  logic       re,
  input  logic [7:0] raddr,
  output logic [7:0] rdata
);
  logic [7:0] mem [RC4_SBOX_DEPTH];
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= we && waddr == raddr ? wdata : mem[raddr];
  end
endmodule

// File: rtl/rc4_keystream_gen.sv
// rc4_keystream_gen: RC4 KSA + PRGA keystream generator; define RC4_DROP_EN to discard the first RC4_DROP_COUNT bytes
module rc4_keystream_gen
  import rc4_pkg::*;
#(
  parameter int KEY_MAX_BYTES = 16,
  parameter int LEN_W = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic [KEY_MAX_BYTES*8-1:0] key,
  input  logic [5:0]                 key_len,
  input  logic [LEN_W-1:0]           out_len,
  output logic                       busy,
  output logic [7:0]                 ks_data,
  output logic                       ks_valid,
  input  logic                       ks_ready,
  output logic                       done,
  output logic                       err
);
  rc4_state_e st, st_n;
  logic [1:0] ph;
  logic [7:0] i, j, si, t, pw_addr, pw_data, i1, kbyte, rdata, raddr, waddr, wdata;
  logic [KEY_MAX_BYTES*8-1:0] key_q;
  logic [5:0] klen, kidx;
  logic [LEN_W-1:0] rem;
  logic pend, re, we, key_ok, in_out, dropping, fire, last_i;
`ifdef RC4_DROP_EN
  logic [9:0] drop_cnt;
  assign dropping = drop_cnt != 10'(RC4_DROP_COUNT);
`else
  assign dropping = 1'b0;
`endif
  assign i1 = i + 8'd1;
  assign last_i = i == 8'hff;
  assign key_ok = key_len != 6'd0 && int'(key_len) <= KEY_MAX_BYTES;
  assign in_out = st == ST_PRGA && ph == 2'd3;
  assign ks_valid = in_out && !dropping;
  assign fire = in_out && (dropping || ks_ready);
  assign ks_data = ks_valid ? (t == j ? si : rdata) : 8'h00;
  assign busy = st != ST_IDLE;
  always_comb begin
    kbyte = 8'h00;
    for (int n = 0; n < KEY_MAX_BYTES; n++) kbyte = kidx == n[5:0] ? key_q[8*n +: 8] : kbyte;
  end
  always_comb begin
    re = (st == ST_KSA && ph != 2'd2) || (st == ST_PRGA && ph != 2'd3) || fire;
    raddr = st == ST_KSA ? (ph == 2'd0 ? i : j + rdata + kbyte)
          : ph == 2'd1 ? j + rdata : ph == 2'd2 ? si + rdata : i1;
    we = st == ST_INIT || (ph == 2'd2 && (st == ST_KSA || st == ST_PRGA)) || pend;
    waddr = st == ST_INIT || ph == 2'd2 ? i : pw_addr;
    wdata = st == ST_INIT ? i : ph == 2'd2 ? rdata : pw_data;
  end
  always_comb begin
    st_n = st;
    case (st)
      ST_IDLE: st_n = start && key_ok ? ST_INIT : ST_IDLE;
      ST_INIT: st_n = last_i ? ST_KSA : ST_INIT;
      ST_KSA:  st_n = ph == 2'd2 && last_i ? (rem == '0 ? ST_IDLE : ST_PRGA) : ST_KSA;
      default: st_n = fire && !dropping && rem == LEN_W'(1) ? ST_IDLE : ST_PRGA;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st <= ST_IDLE;
      ph <= 2'd0;
      i <= 8'd0;
      j <= 8'd0;
      pend <= 1'b0;
      done <= 1'b0;
      err <= 1'b0;
`ifdef RC4_DROP_EN
      drop_cnt <= 10'd0;
`endif
    end else begin
      st <= st_n;
      pend <= 1'b0;
      done <= 1'b0;
      err <= st == ST_IDLE && start && !key_ok;
      case (st)
        ST_IDLE: if (start && key_ok) begin
          key_q <= key;
          klen <= key_len;
          rem <= out_len;
          i <= 8'd0;
          j <= 8'd0;
          ph <= 2'd0;
          kidx <= 6'd0;
`ifdef RC4_DROP_EN
          drop_cnt <= 10'd0;
`endif
        end
        ST_INIT: i <= i1;
        default: case (ph)
          2'd0: begin
            if (st == ST_PRGA) i <= i1;
            ph <= 2'd1;
          end
          2'd1: begin
            si <= rdata;
            j <= raddr;
            ph <= 2'd2;
          end
          2'd2: begin
            pend <= 1'b1;
            pw_addr <= j;
            pw_data <= si;
            t <= raddr;
            if (st == ST_KSA) begin
              i <= i1;
              kidx <= kidx == klen - 6'd1 ? 6'd0 : kidx + 6'd1;
              ph <= 2'd0;
              if (last_i) j <= 8'd0;
              done <= last_i && rem == '0;
            end else ph <= 2'd3;
          end
          default: if (fire) begin
            i <= i1;
            ph <= 2'd1;
            if (!dropping) rem <= rem - LEN_W'(1);
            done <= !dropping && rem == LEN_W'(1);
`ifdef RC4_DROP_EN
            if (dropping) drop_cnt <= drop_cnt + 10'd1;
`endif
          end
        endcase
      endcase
    end
  end
  rc4_sbox_ram u_sbox (
    .clk   (clk),
    .we    (we),
    .waddr (waddr),
    .wdata (wdata),
    .re    (re),
    .raddr (raddr),
    .rdata (rdata)
  );
endmodule

// File: tb/tb_rc4_keystream_gen.sv
// tb_rc4_keystream_gen: checks rc4_keystream_gen against a software RC4 model and known test vectors
module tb_rc4_keystream_gen;
  localparam int KMAX = 16;
  localparam int LW = 16;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, ks_ready = 1'b0;
  logic [KMAX*8-1:0] key = '0;
  logic [5:0] key_len = '0;
  logic [LW-1:0] out_len = '0;
  logic busy, ks_valid, done, err;
  logic [7:0] ks_data;
  rc4_keystream_gen #(.KEY_MAX_BYTES(KMAX), .LEN_W(LW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .key      (key),
    .key_len  (key_len),
    .out_len  (out_len),
    .busy     (busy),
    .ks_data  (ks_data),
    .ks_valid (ks_valid),
    .ks_ready (ks_ready),
    .done     (done),
    .err      (err)
  );
  always #5 clk = ~clk;
  int pass_cnt = 0, tot_cnt = 0, cyc = 0, hs_cnt = 0, vcnt = 0, err_cnt = 0;
  int last_hs = -1, first_hs = -1, sess = 0, cur_sess = 0;
  bit rand_ready = 1'b0, prev_stall = 1'b0;
  logic [7:0] prev_data;
  logic [7:0] exp_q[$];
  logic [7:0] mq[$];
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tot_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
  endtask
  function automatic logic [255:0] str_key(input string s);
    logic [255:0] k = '0;
    for (int n = 0; n < s.len(); n++) k[8*n +: 8] = s[n];
    return k;
  endfunction
  task automatic model(input logic [255:0] kb, input int klen, input int n);
    int s[256];
    int a, b, tmp, drop;
`ifdef RC4_DROP_EN
    drop = 768;
`else
    drop = 0;
`endif
    for (int x = 0; x < 256; x++) s[x] = x;
    b = 0;
    for (int x = 0; x < 256; x++) begin
      b = (b + s[x] + int'(kb[8*(x % klen) +: 8])) % 256;
      tmp = s[x]; s[x] = s[b]; s[b] = tmp;
    end
    a = 0;
    b = 0;
    mq.delete();
    for (int x = 0; x < n + drop; x++) begin
      a = (a + 1) % 256;
      b = (b + s[a]) % 256;
      tmp = s[a]; s[a] = s[b]; s[b] = tmp;
      if (x >= drop) mq.push_back(8'(s[(s[a] + s[b]) % 256]));
    end
  endtask
  task automatic pin(input string s, input logic [63:0] v, input int n);
    model(str_key(s), s.len(), n);
    for (int k = 0; k < n; k++) chk($sformatf("model_%s[%0d]", s, k), mq[k], v[8*(n-1-k) +: 8]);
  endtask
  initial forever begin
    @(posedge clk);
    #1;
    ks_ready = rand_ready ? ($urandom_range(0, 1) == 1) : 1'b1;
  end
  always @(negedge clk) begin
    cyc++;
    if (sess != cur_sess) begin
      cur_sess = sess;
      last_hs = -1;
      first_hs = -1;
    end
    if (!rst_n) prev_stall = 1'b0;
    else begin
      if (prev_stall) begin
        chk("stall_valid", ks_valid, 1);
        chk("stall_data", ks_data, prev_data);
      end
      if (ks_valid) vcnt++;
      if (err) err_cnt++;
      if (ks_valid && ks_ready) begin
        if (exp_q.size() == 0) begin
          tot_cnt++;
          $display("FAIL unexpected_byte: got 0x%0h, expected no byte", ks_data);
        end else chk($sformatf("ks_data[%0d]", hs_cnt), ks_data, exp_q.pop_front());
        if (!rand_ready && last_hs >= 0) chk("byte_spacing", cyc - last_hs, 3);
        if (first_hs < 0) first_hs = cyc;
        last_hs = cyc;
        hs_cnt++;
      end
      prev_stall = ks_valid && !ks_ready;
      prev_data = ks_data;
    end
  end
  task automatic session(input string s, input int olen, input bit rnd, input bit poke);
    logic [255:0] kb;
    int e0, h0, v0, t0, n;
    kb = str_key(s);
    model(kb, s.len(), olen);
    exp_q = mq;
    rand_ready = rnd;
    sess++;
    e0 = err_cnt;
    h0 = hs_cnt;
    v0 = vcnt;
    @(posedge clk);
    #1;
    start = 1'b1;
    key = kb[KMAX*8-1:0];
    key_len = 6'(s.len());
    out_len = LW'(olen);
    t0 = cyc;
    @(posedge clk);
    #1;
    start = 1'b0;
    key = '1;
    key_len = 6'd5;
    out_len = LW'(3);
    @(negedge clk);
    chk("busy_rise", busy, 1);
    if (poke) begin
      repeat (20) @(posedge clk);
      #1;
      start = 1'b1;
      key_len = 6'd0;
      @(posedge clk);
      #1;
      start = 1'b0;
    end
    n = 0;
    while (!done && n < 1100 + 12 * olen) begin
      @(negedge clk);
      n++;
    end
    chk("done_seen", done, 1);
    chk("busy_at_done", busy, 0);
    chk("bytes_left", exp_q.size(), 0);
    chk("byte_count", hs_cnt - h0, olen);
    chk("err_while_busy", err_cnt, e0);
    if (olen == 0) chk("no_valid", vcnt - v0, 0);
    else if (!rnd) chk("first_byte_latency_ok", first_hs - t0 <= 1029, 1);
    @(negedge clk);
    chk("done_pulse", done, 0);
  endtask
  task automatic bad_start(input logic [5:0] kl);
    @(posedge clk);
    #1;
    start = 1'b1;
    key_len = kl;
    out_len = LW'(4);
    @(posedge clk);
    #1;
    start = 1'b0;
    @(negedge clk);
    chk($sformatf("err_pulse_len%0d", kl), err, 1);
    chk("err_busy", busy, 0);
    @(negedge clk);
    chk("err_one_cycle", err, 0);
    chk("err_busy_after", busy, 0);
  endtask
  initial begin
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_valid", ks_valid, 0);
    chk("rst_data", ks_data, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
`ifndef RC4_DROP_EN
    pin("Key", 64'hEB9F7781B734CA72, 8);
    pin("Wiki", 64'h00006044DB6D41B7, 6);
    pin("Secret", 64'h04D46B053CA87B59, 8);
`endif
    session("Key", 8, 1'b0, 1'b0);
    session("Wiki", 6, 1'b0, 1'b1);
    session("Secret", 8, 1'b1, 1'b0);
    bad_start(6'd0);
    bad_start(6'(KMAX + 1));
    session("Key", 0, 1'b0, 1'b0);
    model(str_key("Key"), 3, 600);
    exp_q = mq;
    rand_ready = 1'b0;
    sess++;
    @(posedge clk);
    #1;
    start = 1'b1;
    key = str_key("Key");
    key_len = 6'd3;
    out_len = LW'(600);
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (1100) @(negedge clk);
    chk("mid_session_busy", busy, 1);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    exp_q.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("midrst_busy", busy, 0);
    chk("midrst_valid", ks_valid, 0);
    chk("midrst_data", ks_data, 0);
    chk("midrst_done", done, 0);
    chk("midrst_err", err, 0);
    session("Key", 600, 1'b0, 1'b0);
    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end
endmodule

// File: doc/rc4_keystream_gen.md
RC4_KEYSTREAM_GEN -- requirements
Module: rc4_keystream_gen

Interface
REQ-001 SHALL have parameter KEY_MAX_BYTES, default 16, maximum supported key length in bytes (range 1..32).
REQ-002 SHALL have parameter LEN_W, default 16, width of the requested output-byte count.
REQ-003 SHALL have port clk  input  1  rising-edge clock.
REQ-004 SHALL have port rst_n  input  1  reset: synchronous, active-low.
REQ-005 SHALL have port start  input  1  single-cycle request to begin a session; sampled only in IDLE.
REQ-006 SHALL have port key  input  KEY_MAX_BYTES*8  key bytes; byte n at key[8n+7:8n]; byte 0 is the first key byte.
REQ-007 SHALL have port key_len  input  6  active key length in bytes.
REQ-008 SHALL have port out_len  input  LEN_W  number of keystream bytes to emit.
REQ-009 SHALL have port busy  output  1  high from the cycle after an accepted start until done.
REQ-010 SHALL have port ks_data  output  8  keystream byte.
REQ-011 SHALL have port ks_valid  output  1  ks_data is valid.
REQ-012 SHALL have port ks_ready  input  1  consumer accepts the byte when ks_valid && ks_ready.
REQ-013 SHALL have port done  output  1  one-cycle pulse after the last byte is accepted.
REQ-014 SHALL have port err  output  1  one-cycle pulse when start is rejected.

Function
REQ-015 SHALL implement FSM states IDLE -> INIT -> KSA -> PRGA -> IDLE.
REQ-016 SHALL latch key, key_len and out_len on accepted start; later input changes have no effect on the session.
REQ-017 SHALL reject start with key_len==0 or key_len>KEY_MAX_BYTES: err pulses next cycle, state stays IDLE.
REQ-018 INIT SHALL write S[i]=i for i=0..255, one entry per cycle (256 cycles).
REQ-019 KSA SHALL take exactly 3 cycles per i (read S[i]; j=j+S[i]+key[i mod key_len] mod 256 and read S[j]; swap), 768 cycles total.
REQ-020 PRGA SHALL start with i=j=0 and compute i=i+1, j=j+S[i], swap, then present S[(S[i]+S[j]) mod 256].
REQ-021 SHALL present the first ks_valid no later than 4 cycles after KSA ends; with ks_ready held high, consecutive bytes SHALL be 3 cycles apart.
REQ-022 SHALL hold ks_data stable and ks_valid high while ks_valid && !ks_ready, and SHALL not advance i, j or S.
REQ-023 A swap with i==j SHALL leave S unchanged.
REQ-024 i and j SHALL wrap 255->0 without any side effect; sessions longer than 256 bytes are legal.
REQ-025 With out_len==0, SHALL go from KSA directly to IDLE, pulse done and emit no bytes.
REQ-026 SHALL pulse done in the cycle after the out_len-th byte handshake; busy SHALL fall in the same cycle.
REQ-027 start asserted while busy SHALL be ignored, with no err pulse.

Reset
REQ-028 rst_n low SHALL force IDLE, i=j=0 and busy, ks_valid, done and err to 0, and ks_data to 0x00, at any time including mid-session.
REQ-029 S-box contents need no reset; INIT rewrites them every session.

Configuration
REQ-030 With RC4_DROP_EN defined, SHALL discard the first RC4_DROP_COUNT PRGA bytes internally: no ks_valid, not counted toward out_len.
REQ-031 Without RC4_DROP_EN, SHALL emit from the first PRGA byte, and no drop counter SHALL exist.

Structure
REQ-032 Package rc4_pkg SHALL hold the FSM state enum, RC4_SBOX_DEPTH=256 and RC4_DROP_COUNT=768.
REQ-033 SHALL instantiate sub-module rc4_sbox_ram: 256x8, one read port and one write port, 1-cycle read latency, write-first on same-address collision.

Verification
REQ-034 key "Key" (0x4B,0x65,0x79), key_len=3, out_len=8, ready=1 -> EB 9F 77 81 B7 34 CA 72, then done.
REQ-035 key "Wiki", key_len=4, out_len=6 -> 60 44 DB 6D 41 B7.
REQ-036 key "Secret", key_len=6, out_len=8, ks_ready toggled randomly -> 04 D4 6B 05 3C A8 7B 59, with ks_data stable during every stall.
REQ-037 key_len=0 and key_len=KEY_MAX_BYTES+1 -> err pulse, busy stays 0; out_len=0 -> done after 1024+ cycles with no ks_valid.
REQ-038 rst_n low for 1 cycle mid-PRGA, then restart with "Key" -> outputs zero, then correct stream; out_len=600 -> crosses the i wrap and matches the software model.
